alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one single-cycle ALU datapath (32-bit A/B, 4-bit select) between NUM_REQ requesters.
- Each requester has its own valid/ready request channel and a valid/ready response channel.
- Grants use round-robin, and only one operation is in flight at a time.
- Operands are registered before the ALU and the result is registered after it, so the ALU sits between two flop stages.

Parameters:
- WIDTH_DATA_LENGTH, 32, operand and result width.
- WIDTH_SEL_LENGTH, 4, ALU select width.
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, 3, width of the grant index; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  NUM_REQ*WIDTH_DATA_LENGTH  packed operand A; lane i is bits [i*W +: W].
- req_b  input  NUM_REQ*WIDTH_DATA_LENGTH  packed operand B, same packing.
- req_sel  input  NUM_REQ*WIDTH_SEL_LENGTH  packed ALU select.
- rsp_valid  output  NUM_REQ  per-requester response valid; one-hot or zero.
- rsp_ready  input  NUM_REQ  per-requester response accept.
- rsp_data  output  WIDTH_DATA_LENGTH  shared result bus; meaningful only where rsp_valid is set.
- busy  output  1  high whenever state is not IDLE.
- grant_id  output  ID_W  index of the requester currently owning the ALU.

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - req_ready=0, rsp_valid=0, rsp_data=0, busy=0, grant_id=0.
  - Operand, select and result registers cleared to 0.
  - last_grant=NUM_REQ-1, so requester 0 has first priority.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching (last_grant+1) mod NUM_REQ upward with wrap.
  - req_ready[winner]=1 combinationally; every other lane is 0.
  - With no valid request, all req_ready=0 and state stays IDLE.
  - On the edge with valid&ready: capture that lane's a, b and sel into op registers, set grant_id=winner, go to EXEC.
- EXEC (exactly 1 cycle): the ALU sees only the op registers. rsp_data_reg <= ALU result. Go to RESP.
- RESP:
  - rsp_valid[grant_id]=1 and rsp_data=rsp_data_reg; both stay stable until handshake.
  - When rsp_ready[grant_id]=1: last_grant<=grant_id, rsp_valid drops next cycle, state goes to IDLE.
  - rsp_ready on non-granted lanes is ignored.
- Timing:
  - Latency: request accepted at edge N, so rsp_valid is high from cycle N+2.
  - Minimum of 3 cycles per operation.
  - A new request cannot be accepted in the same cycle as a response handshake.
- req_ready is 0 in EXEC and RESP. Requesters may drop req_valid at any time without a handshake; nothing is captured.
- ALU select codes:
  - 0000 add; 0001 sub; 0010 sll; 0011 slt; 0100 sltu.
  - 0101 xor; 0110 srl; 0111 sra; 1000 or; 1001 and.
  - Codes 1010-1111 execute as add.
  - Arithmetic wraps modulo 2^WIDTH_DATA_LENGTH.
- Simultaneous requests from all lanes are served strictly in rotation. No lane waits more than NUM_REQ-1 other operations.
- Reset mid-EXEC or mid-RESP drops the transaction: no response is produced, and after reset requester 0 has priority again.
- busy=1 in EXEC and RESP.

Decomposition:
- Shared package holds:
  - ALU select constants: ALU_ADD..ALU_AND, 4'b0000..4'b1001.
  - State encoding: IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
- Sub-module rr_pick (combinational): inputs are the req_valid vector and last_grant; outputs are a one-hot grant and a grant index.
- The ALU is instantiated unchanged inside the block, fed only from the op registers.

Test Plan:
- Reset, then lane0 sends A=5, B=3, sel=0000 (accepted at edge 1) -> rsp_valid[0]=1 from cycle 3 with rsp_data=8; rsp_valid[1]=0 throughout.
- Lanes 0 and 1 both valid continuously with lane0 sub 10-3 and lane1 xor 0xFF00^0x0FF0, rsp_ready tied 1 -> grants alternate 0,1,0,1; data 7 and 0xF0F0; first grant goes to lane0.
- Lane1 requests A=0xFFFFFFFF, B=1, add, and holds rsp_ready=0 for 5 cycles -> rsp_valid[1] and rsp_data=0 stay stable; req_ready=0 for lane0 the whole time; a lane0 request is accepted only after the lane1 handshake.
- Lane0 requests sel=1111 with A=2, B=2 -> rsp_data=4 (default add).
- Assert rst during RESP -> all outputs 0 immediately, no response delivered; a subsequent simultaneous lane0+lane1 request is granted to lane0 first.
- Lane0 raises req_valid for one cycle while the arbiter is in EXEC, then drops it -> never captured; the op count observed on responses is unchanged.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_share_arbiter_pkg
// Brief  : ALU select codes and arbiter state encoding for alu_share_arbiter
// Rev    : 1.0 - initial release
// ============================================================================
package alu_share_arbiter_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : alu_share_arbiter_if
// Brief  : Per-requester request/response channels plus status of the arbiter
// Rev    : 1.0 - initial release
// ============================================================================
interface alu_share_arbiter_if #(
  parameter int WIDTH_DATA_LENGTH = 32,
  parameter int WIDTH_SEL_LENGTH  = 4,
  parameter int NUM_REQ           = 2,
  parameter int ID_W              = 3
);

  logic [NUM_REQ-1:0]                   req_valid;
  logic [NUM_REQ-1:0]                   req_ready;
  logic [NUM_REQ*WIDTH_DATA_LENGTH-1:0] req_a;
  logic [NUM_REQ*WIDTH_DATA_LENGTH-1:0] req_b;
  logic [NUM_REQ*WIDTH_SEL_LENGTH-1:0]  req_sel;
  logic [NUM_REQ-1:0]                   rsp_valid;
  logic [NUM_REQ-1:0]                   rsp_ready;
  logic [WIDTH_DATA_LENGTH-1:0]         rsp_data;
  logic                                 busy;
  logic [ID_W-1:0]                      grant_id;

  modport slave (
    input  req_valid, req_a, req_b, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_data, busy, grant_id
  );

  modport master (
    output req_valid, req_a, req_b, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, busy, grant_id
  );

endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter_alu.sv
`default_nettype none
// ============================================================================
// Module : alu_share_arbiter_alu
// Brief  : Single-cycle combinational ALU; unknown select codes perform add
// Rev    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter_alu
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH_DATA_LENGTH = 32,
  parameter int WIDTH_SEL_LENGTH  = 4
) (
  input  wire logic [WIDTH_DATA_LENGTH-1:0] i_a,
  input  wire logic [WIDTH_DATA_LENGTH-1:0] i_b,
  input  wire logic [WIDTH_SEL_LENGTH-1:0]  i_sel,
  output logic      [WIDTH_DATA_LENGTH-1:0] o_y
);

  localparam int SH_W = $clog2(WIDTH_DATA_LENGTH);

  logic [SH_W-1:0] w_shamt;

  assign w_shamt = i_b[SH_W-1:0];

  always_comb begin
    o_y = i_a + i_b;
    case (i_sel)
      ALU_ADD:  o_y = i_a + i_b;
      ALU_SUB:  o_y = i_a - i_b;
      ALU_SLL:  o_y = i_a << w_shamt;
      ALU_SLT:  o_y = {{(WIDTH_DATA_LENGTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      ALU_SLTU: o_y = {{(WIDTH_DATA_LENGTH-1){1'b0}}, (i_a < i_b)};
      ALU_XOR:  o_y = i_a ^ i_b;
      ALU_SRL:  o_y = i_a >> w_shamt;
      ALU_SRA:  o_y = WIDTH_DATA_LENGTH'($signed(i_a) >>> w_shamt);
      ALU_OR:   o_y = i_a | i_b;
      ALU_AND:  o_y = i_a & i_b;
      default:  o_y = i_a + i_b;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_share_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : alu_share_arbiter_rr_pick
// Brief  : Combinational round-robin picker starting just after the last grant
// Rev    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 3
) (
  input  wire logic [NUM_REQ-1:0] i_req_valid,
  input  wire logic [ID_W-1:0]    i_last_grant,
  output logic      [NUM_REQ-1:0] o_grant,
  output logic      [ID_W-1:0]    o_grant_id
);

  logic w_found;

  // Lanes above the last grant win first, then the search wraps to lane 0.
  always_comb begin
    o_grant    = '0;
    o_grant_id = '0;
    w_found    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && (i > int'(i_last_grant)) && i_req_valid[i]) begin
        w_found    = 1'b1;
        o_grant[i] = 1'b1;
        o_grant_id = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && (i <= int'(i_last_grant)) && i_req_valid[i]) begin
        w_found    = 1'b1;
        o_grant[i] = 1'b1;
        o_grant_id = ID_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module : alu_share_arbiter
// Brief  : Round-robin sharing of one registered-in/registered-out ALU
// Rev    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH_DATA_LENGTH = 32,
  parameter int WIDTH_SEL_LENGTH  = 4,
  parameter int NUM_REQ           = 2,
  parameter int ID_W              = 3
) (
  input  wire logic           clk,
  input  wire logic           rst,
  alu_share_arbiter_if.slave  bus
);

  localparam int W = WIDTH_DATA_LENGTH;
  localparam int S = WIDTH_SEL_LENGTH;

  state_t             r_state;
  logic [ID_W-1:0]    r_last_grant;
  logic [ID_W-1:0]    r_grant_id;
  logic [NUM_REQ-1:0] r_grant_oh;
  logic [W-1:0]       r_op_a;
  logic [W-1:0]       r_op_b;
  logic [S-1:0]       r_op_sel;
  logic [W-1:0]       r_rsp_data;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic               r_busy;

  logic [NUM_REQ-1:0] w_pick_oh;
  logic [ID_W-1:0]    w_pick_id;
  logic [NUM_REQ-1:0] w_req_ready;
  logic               w_accept;
  logic               w_rsp_done;
  logic [W-1:0]       w_cap_a;
  logic [W-1:0]       w_cap_b;
  logic [S-1:0]       w_cap_sel;
  logic [W-1:0]       w_alu_y;

  alu_share_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .i_req_valid  (bus.req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_pick_oh),
    .o_grant_id   (w_pick_id)
  );

  alu_share_arbiter_alu #(
    .WIDTH_DATA_LENGTH (W),
    .WIDTH_SEL_LENGTH  (S)
  ) u_alu (
    .i_a   (r_op_a),
    .i_b   (r_op_b),
    .i_sel (r_op_sel),
    .o_y   (w_alu_y)
  );

  assign w_req_ready = (r_state == IDLE) ? w_pick_oh : '0;
  assign w_accept    = |(w_req_ready & bus.req_valid);
  // r_rsp_valid is one-hot on the owner, so this ignores other lanes' ready.
  assign w_rsp_done  = (r_state == RESP) && |(r_rsp_valid & bus.rsp_ready);

  always_comb begin
    w_cap_a   = '0;
    w_cap_b   = '0;
    w_cap_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick_oh[i]) begin
        w_cap_a   = bus.req_a[i*W +: W];
        w_cap_b   = bus.req_b[i*W +: W];
        w_cap_sel = bus.req_sel[i*S +: S];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= ID_W'(NUM_REQ - 1);
      r_grant_id   <= '0;
      r_grant_oh   <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_sel     <= '0;
      r_rsp_data   <= '0;
      r_rsp_valid  <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op_a     <= w_cap_a;
            r_op_b     <= w_cap_b;
            r_op_sel   <= w_cap_sel;
            r_grant_id <= w_pick_id;
            r_grant_oh <= w_pick_oh;
            r_busy     <= 1'b1;
            r_state    <= EXEC;
          end
        end
        EXEC: begin
          r_rsp_data  <= w_alu_y;
          r_rsp_valid <= r_grant_oh;
          r_state     <= RESP;
        end
        RESP: begin
          if (w_rsp_done) begin
            r_last_grant <= r_grant_id;
            r_rsp_valid  <= '0;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_rsp_valid <= '0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.busy      = r_busy;
  assign bus.grant_id  = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_share_arbiter
// Brief  : Directed self-checking bench for alu_share_arbiter
// Rev    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  alu_share_arbiter_if #(.WIDTH_DATA_LENGTH(32), .WIDTH_SEL_LENGTH(4), .NUM_REQ(2), .ID_W(3)) bus ();

  alu_share_arbiter #(
    .WIDTH_DATA_LENGTH (32),
    .WIDTH_SEL_LENGTH  (4),
    .NUM_REQ           (2),
    .ID_W              (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  s;
    logic [31:0] e;
  } vec_t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int lane, input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    bus.req_a[lane*32 +: 32] = a;
    bus.req_b[lane*32 +: 32] = b;
    bus.req_sel[lane*4 +: 4] = s;
  endtask

  // Called at a negedge with the arbiter idle; returns at a negedge, idle again.
  task automatic run_op(input int lane, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] s, input logic [31:0] e, input int hold);
    int n;
    set_lane(lane, a, b, s);
    bus.req_valid[lane] = 1'b1;
    #1;
    n = 0;
    while (bus.req_ready[lane] !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("accept", 64'(bus.req_ready[lane]), 64'd1);
    @(negedge clk);
    bus.req_valid[lane] = 1'b0;
    check("exec_busy", 64'(bus.busy), 64'd1);
    check("exec_grant", 64'(bus.grant_id), 64'(lane));
    @(negedge clk);
    check("rsp_valid", 64'(bus.rsp_valid), 64'd1 << lane);
    check("rsp_data", 64'(bus.rsp_data), 64'(e));
    repeat (hold) begin
      @(negedge clk);
      check("rsp_hold", 64'(bus.rsp_data), 64'(e));
    end
    bus.rsp_ready[lane] = 1'b1;
    @(negedge clk);
    bus.rsp_ready[lane] = 1'b0;
    check("rsp_drop", 64'(bus.rsp_valid), 64'd0);
  endtask

  vec_t tv[11] = '{
    '{32'h0000_0003, 32'h0000_0005, 4'b0001, 32'hFFFF_FFFE},
    '{32'h0000_0001, 32'h0000_0004, 4'b0010, 32'h0000_0010},
    '{32'hFFFF_FFFF, 32'h0000_0001, 4'b0011, 32'h0000_0001},
    '{32'hFFFF_FFFF, 32'h0000_0001, 4'b0100, 32'h0000_0000},
    '{32'h8000_0000, 32'h0000_0004, 4'b0110, 32'h0800_0000},
    '{32'h8000_0000, 32'h0000_0004, 4'b0111, 32'hF800_0000},
    '{32'h0000_00F0, 32'h0000_000F, 4'b1000, 32'h0000_00FF},
    '{32'h0000_00F0, 32'h0000_003C, 4'b1001, 32'h0000_0030},
    '{32'h0000_00FF, 32'h0000_000F, 4'b0101, 32'h0000_00F0},
    '{32'h0000_0002, 32'h0000_0021, 4'b0010, 32'h0000_0004},
    '{32'h0000_0002, 32'h0000_0002, 4'b1111, 32'h0000_0004}
  };

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_lane;
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sel   = '0;
    bus.rsp_ready = '0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_grant_id", 64'(bus.grant_id), 64'd0);
    rst = 1'b0;

    // Basic add on lane 0, then the select-code table alternating lanes.
    run_op(0, 32'd5, 32'd3, 4'b0000, 32'd8, 0);
    foreach (tv[i]) run_op(i % 2, tv[i].a, tv[i].b, tv[i].s, tv[i].e, (i == 3) ? 2 : 0);

    // Rotation with both lanes always valid and responses always accepted.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_lane(0, 32'd10, 32'd3, 4'b0001);
    set_lane(1, 32'h0000_FF00, 32'h0000_0FF0, 4'b0101);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_lane = k % 2;
      check("rr_ready", 64'(bus.req_ready), 64'd1 << exp_lane);
      @(negedge clk);
      check("rr_grant", 64'(bus.grant_id), 64'(exp_lane));
      @(negedge clk);
      check("rr_rsp_valid", 64'(bus.rsp_valid), 64'd1 << exp_lane);
      check("rr_rsp_data", 64'(bus.rsp_data), (exp_lane == 0) ? 64'd7 : 64'h0000_F0F0);
      @(negedge clk);
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;

    // Lane 1 stalls its response; lane 0 must wait for the handshake.
    set_lane(1, 32'hFFFF_FFFF, 32'd1, 4'b0000);
    bus.req_valid[1] = 1'b1;
    #1;
    check("stall_ready1", 64'(bus.req_ready), 64'b10);
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    set_lane(0, 32'd1, 32'd1, 4'b0000);
    bus.req_valid[0] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("stall_rsp_valid", 64'(bus.rsp_valid), 64'b10);
      check("stall_rsp_data", 64'(bus.rsp_data), 64'd0);
      check("stall_ready0", 64'(bus.req_ready), 64'd0);
      bus.rsp_ready[0] = 1'b1;
      @(negedge clk);
      bus.rsp_ready[0] = 1'b0;
    end
    bus.rsp_ready[1] = 1'b1;
    @(negedge clk);
    bus.rsp_ready[1] = 1'b0;
    check("stall_then_ready0", 64'(bus.req_ready), 64'b01);
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    check("stall_lane0_valid", 64'(bus.rsp_valid), 64'b01);
    check("stall_lane0_data", 64'(bus.rsp_data), 64'd2);
    bus.rsp_ready[0] = 1'b1;
    @(negedge clk);
    bus.rsp_ready[0] = 1'b0;

    // Reset while a lane 1 response is pending.
    set_lane(1, 32'd7, 32'd1, 4'b0000);
    bus.req_valid[1] = 1'b1;
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    @(negedge clk);
    check("pre_rst_rsp", 64'(bus.rsp_valid), 64'b10);
    rst = 1'b1;
    #1;
    check("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_grant", 64'(bus.grant_id), 64'd0);
    check("mid_rst_data", 64'(bus.rsp_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    set_lane(0, 32'd20, 32'd22, 4'b0000);
    bus.req_valid = 2'b11;
    #1;
    check("post_rst_ready", 64'(bus.req_ready), 64'b01);
    @(negedge clk);
    bus.req_valid = 2'b00;
    check("post_rst_grant", 64'(bus.grant_id), 64'd0);
    @(negedge clk);
    check("post_rst_rsp", 64'(bus.rsp_valid), 64'b01);
    check("post_rst_data", 64'(bus.rsp_data), 64'd42);
    bus.rsp_ready[0] = 1'b1;
    @(negedge clk);
    bus.rsp_ready[0] = 1'b0;

    // Lane 0 pulses valid only during EXEC and must never be captured.
    set_lane(1, 32'd4, 32'd4, 4'b0000);
    bus.req_valid[1] = 1'b1;
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    set_lane(0, 32'd100, 32'd1, 4'b0000);
    bus.req_valid[0] = 1'b1;
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    check("pulse_rsp_valid", 64'(bus.rsp_valid), 64'b10);
    check("pulse_rsp_data", 64'(bus.rsp_data), 64'd8);
    bus.rsp_ready[1] = 1'b1;
    @(negedge clk);
    bus.rsp_ready[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("pulse_idle_busy", 64'(bus.busy), 64'd0);
      check("pulse_idle_rsp", 64'(bus.rsp_valid), 64'd0);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
